apb_mem_slave: RTL and testbench

APB completer that owns a small register-file memory and answers the transfers issued by the team's APB master. It sits directly downstream of the master on the P_* bus and is the memory endpoint of the APB subsystem. It supports a configurable number of wait states, signals out-of-range accesses with P_slverr, and keeps a saturating error counter for debug.

---
 rtl/apb_mem_slave.sv | 97 +++++++++
 tb/tb_apb_mem_slave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer backed by a small register-file memory
// Ports: P_clk/P_reset_n clock and async active-low reset; P_sel/P_enable/P_write/P_addr/P_wdata
// from the master; P_rdata/P_ready/P_slverr registered response; err_count saturating error tally.
module apb_mem_slave #(
  parameter int ADDR_width  = 4,
  parameter int DATA_width  = 8,
  parameter int MEM_depth   = 12,
  parameter int WAIT_cycles = 1
) (
  input  logic                  P_clk,
  input  logic                  P_reset_n,
  input  logic                  P_sel,
  input  logic                  P_enable,
  input  logic                  P_write,
  input  logic [ADDR_width-1:0] P_addr,
  input  logic [DATA_width-1:0] P_wdata,
  output logic [DATA_width-1:0] P_rdata,
  output logic                  P_ready,
  output logic                  P_slverr,
  output logic [7:0]            err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_width-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_width-1:0] wdata_q, wdata_d;
  logic [DATA_width-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  slverr_q, slverr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [DATA_width-1:0] mem_q [MEM_depth];
  logic [DATA_width-1:0] mem_d [MEM_depth];
  logic                  err;
  assign err       = int'(addr_q) >= MEM_depth;
  assign P_rdata   = rdata_q;
  assign P_ready   = ready_q;
  assign P_slverr  = slverr_q;
  assign err_count = err_cnt_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    slverr_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    mem_d     = mem_q;
    case (state_q)
      IDLE: if (P_sel) begin
        addr_d  = P_addr;
        write_d = P_write;
        wdata_d = P_wdata;
        cnt_d   = 4'(WAIT_cycles);
        state_d = WAIT;
      end
      WAIT: if (!P_sel) state_d = IDLE;
      else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else if (P_enable) begin
        if (write_q && !err) mem_d[addr_q] = wdata_q;
        if (!write_q) rdata_d = err ? '0 : mem_q[addr_q];
        ready_d  = 1'b1;
        slverr_d = err;
        if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        state_d  = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      slverr_q  <= 1'b0;
      err_cnt_q <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      slverr_q  <= slverr_d;
      err_cnt_q <= err_cnt_d;
      mem_q     <= mem_d;
    end
  end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: randomized scoreboard bench for apb_mem_slave
module tb_apb_mem_slave;
  localparam int W     = 3;
  localparam int DEPTH = 12;
  logic       P_clk = 1'b0;
  logic       P_reset_n = 1'b0;
  logic       P_sel = 1'b0;
  logic       P_enable = 1'b0;
  logic       P_write = 1'b0;
  logic [3:0] P_addr = '0;
  logic [7:0] P_wdata = '0;
  logic [7:0] P_rdata;
  logic       P_ready;
  logic       P_slverr;
  logic [7:0] err_count;
  apb_mem_slave #(.ADDR_width(4), .DATA_width(8), .MEM_depth(DEPTH), .WAIT_cycles(W)) dut (
    .P_clk(P_clk), .P_reset_n(P_reset_n), .P_sel(P_sel), .P_enable(P_enable),
    .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata), .P_rdata(P_rdata),
    .P_ready(P_ready), .P_slverr(P_slverr), .err_count(err_count)
  );
  always #5 P_clk = ~P_clk;
  typedef struct {
    int         cap;
    int         lat;
    bit         err;
    logic [7:0] rd;
    logic [7:0] ec;
  } exp_t;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] mdl [16];
  logic [7:0] last_rd = '0;
  int         mdl_ec = 0;
  bit         prev_ready = 1'b0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    last_rd = '0;
    mdl_ec  = 0;
    sb.delete();
  endtask
  always @(posedge P_clk) cyc++;
  always @(negedge P_clk) begin
    if (!P_reset_n) prev_ready = 1'b0;
    else begin
      if (P_ready) begin
        chk("ready_width", {31'b0, prev_ready}, 0);
        if (sb.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - e.cap, e.lat);
          chk("slverr", {31'b0, P_slverr}, {31'b0, e.err});
          chk("rdata", {24'b0, P_rdata}, {24'b0, e.rd});
          chk("err_count", {24'b0, err_count}, {24'b0, e.ec});
        end
      end
      prev_ready = P_ready;
    end
  end
  // d: P_enable rises with P_sel when d<0, else after the d-th edge following capture
  task automatic xfer(input bit wr, input int addr, input logic [7:0] data, input int d);
    exp_t e;
    bit   err;
    @(negedge P_clk);
    P_sel = 1'b1; P_enable = (d < 0); P_write = wr; P_addr = 4'(addr); P_wdata = data;
    err = addr >= DEPTH;
    if (err && mdl_ec < 255) mdl_ec++;
    if (wr && !err) mdl[addr] = data;
    if (!wr) last_rd = err ? 8'h00 : mdl[addr];
    e.cap = cyc + 1;
    e.lat = (d + 1 > W + 1) ? d + 1 : W + 1;
    e.err = err;
    e.rd  = last_rd;
    e.ec  = 8'(mdl_ec);
    sb.push_back(e);
    for (int j = 0; ; j++) begin
      @(negedge P_clk);
      P_addr = 4'($urandom); P_wdata = 8'($urandom); P_write = 1'($urandom);
      if (j >= d) P_enable = 1'b1;
      if (P_ready) break;
      if (j == 40) begin
        chk("ready_timeout", {31'b0, P_ready}, 1);
        sb.delete();
        break;
      end
    end
    P_sel = 1'b0; P_enable = 1'b0;
  endtask
  task automatic abort_xfer(input bit wr, input int addr, input logic [7:0] data, input int a);
    @(negedge P_clk);
    P_sel = 1'b1; P_enable = 1'b1; P_write = wr; P_addr = 4'(addr); P_wdata = data;
    for (int j = 0; j <= a; j++) @(negedge P_clk);
    P_sel = 1'b0; P_enable = 1'b0;
    repeat (W + 2) @(negedge P_clk);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge P_clk);
    chk("reset_ready", {31'b0, P_ready}, 0);
    chk("reset_slverr", {31'b0, P_slverr}, 0);
    chk("reset_rdata", {24'b0, P_rdata}, 0);
    chk("reset_err_count", {24'b0, err_count}, 0);
    P_reset_n = 1'b1;
    xfer(0, 0, 8'h00, -1);
    xfer(1, 3, 8'hA5, 0);
    xfer(0, 3, 8'h00, -1);
    xfer(1, 13, 8'hFF, 2);
    xfer(0, 13, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) xfer(0, i, 8'h00, -1);
    xfer(1, 2, 8'h33, 0);
    abort_xfer(1, 2, 8'h5A, W - 1);
    abort_xfer(1, 2, 8'h5A, 0);
    xfer(0, 2, 8'h00, 6);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0)
        abort_xfer(1'($urandom), $urandom_range(0, 15), 8'($urandom), $urandom_range(0, W - 1));
      else
        xfer(1'($urandom), $urandom_range(0, 15), 8'($urandom), $urandom_range(0, 6) - 1);
    end
    for (int i = 0; i < 260; i++) xfer(0, $urandom_range(DEPTH, 15), 8'h00, -1);
    chk("err_count_saturated", {24'b0, err_count}, 255);
    xfer(1, 1, 8'h22, -1);
    @(negedge P_clk);
    P_sel = 1'b1; P_enable = 1'b1; P_write = 1'b1; P_addr = 4'd1; P_wdata = 8'h11;
    repeat (2) @(negedge P_clk);
    #2 P_reset_n = 1'b0;
    #1;
    chk("async_reset_ready", {31'b0, P_ready}, 0);
    chk("async_reset_err_count", {24'b0, err_count}, 0);
    chk("async_reset_rdata", {24'b0, P_rdata}, 0);
    model_reset();
    @(negedge P_clk);
    P_sel = 1'b0; P_enable = 1'b0;
    P_reset_n = 1'b1;
    xfer(0, 1, 8'h00, -1);
    xfer(0, 3, 8'h00, 0);
    repeat (W + 4) @(negedge P_clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
